score_display_scan: RTL and testbench

//  Reader side of the score BCD interface: takes the four score digits and drives a
//  4-digit multiplexed seven-segment display (active-low anodes/cathodes).

---
 rtl/score_display_scan.sv | 158 +++++++++++++++
 tb/tb_score_display_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_scan.sv
// score_display_scan: scans four BCD score digits onto a 4-digit multiplexed 7-seg display.
// Latency: outputs registered (one cycle after slot update); digits snapshot at each frame wrap.
// No backpressure: free-running scan. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_display_scan #(
  parameter int SCAN_DIV         = 1024,
  parameter int HIGHLIGHT_FRAMES = 64,
  parameter int BLINK_FRAMES     = 32
) (
  input  logic       clk_mode,
  input  logic       rst,
  input  logic [3:0] score_digit3,
  input  logic [3:0] score_digit2,
  input  logic [3:0] score_digit1,
  input  logic [3:0] score_digit0,
  input  logic       game_over,
  output logic [3:0] seg_an,
  output logic [7:0] seg_cat,
  output logic       frame_tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HIGHLIGHT_FRAMES > 1) ? $clog2(HIGHLIGHT_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HL_LAST  = HW'(HIGHLIGHT_FRAMES - 1);
  localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, HIGHLIGHT, BLINK} state_t;

  logic [DW-1:0] r_div;
  logic [1:0]    r_slot;
  logic [15:0]   r_shadow;   // digits shown this frame; also the previous snapshot for change detect
  logic          r_frame_tick;
  state_t        r_state;
  logic [HW-1:0] r_hl_cnt;
  logic [BW-1:0] r_bl_cnt;
  logic          r_bl_on;
  logic [3:0]    r_seg_an;
  logic [7:0]    r_seg_cat;

  logic          w_tc;
  logic          w_wrap;
  logic [15:0]   w_snap;
  logic          w_change;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg7;
  logic          w_lz_blank;
  logic          w_blank;

  assign w_tc     = (r_div == DIV_LAST);
  assign w_wrap   = w_tc && (r_slot == 2'd3);
  assign w_snap   = {score_digit3, score_digit2, score_digit1, score_digit0};
  assign w_change = (w_snap != r_shadow);

  assign seg_an     = r_seg_an;
  assign seg_cat    = r_seg_cat;
  assign frame_tick = r_frame_tick;

  // Slot divider, frame pulse and once-per-frame digit snapshot
  always_ff @(posedge clk_mode or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_slot       <= 2'd0;
      r_shadow     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (w_tc) begin
        r_div  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_wrap) begin
        r_shadow <= w_snap;
      end
    end
  end

  // Display mode FSM, stepped only at frame wrap; blink outranks highlight
  always_ff @(posedge clk_mode or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_hl_cnt <= '0;
      r_bl_cnt <= '0;
      r_bl_on  <= 1'b1;
    end else if (w_wrap) begin
      if (game_over) begin
        if (r_state != BLINK) begin
          r_state  <= BLINK;
          r_bl_cnt <= '0;
          r_bl_on  <= 1'b1;
        end else if (r_bl_cnt == BL_LAST) begin
          r_bl_cnt <= '0;
          r_bl_on  <= ~r_bl_on;
        end else begin
          r_bl_cnt <= r_bl_cnt + BW'(1);
        end
      end else if (r_state == BLINK) begin
        // leaving blink goes straight to plain digits, even if the score moved meanwhile
        r_state <= IDLE;
      end else if (w_change) begin
        r_state  <= HIGHLIGHT;
        r_hl_cnt <= '0;
      end else if (r_state == HIGHLIGHT) begin
        if (r_hl_cnt == HL_LAST) begin
          r_state <= IDLE;
        end else begin
          r_hl_cnt <= r_hl_cnt + HW'(1);
        end
      end
    end
  end

  // Segment decode of the current slot's shadow digit and blanking decision
  always_comb begin
    w_digit = r_shadow[{r_slot, 2'b00} +: 4];
    case (w_digit)
      4'd0:    w_seg7 = 7'h40;
      4'd1:    w_seg7 = 7'h79;
      4'd2:    w_seg7 = 7'h24;
      4'd3:    w_seg7 = 7'h30;
      4'd4:    w_seg7 = 7'h19;
      4'd5:    w_seg7 = 7'h12;
      4'd6:    w_seg7 = 7'h02;
      4'd7:    w_seg7 = 7'h78;
      4'd8:    w_seg7 = 7'h00;
      4'd9:    w_seg7 = 7'h10;
      default: w_seg7 = 7'h3F;  // invalid BCD shows a dash
    endcase
    w_lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // a dash code is nonzero, so it never counts as a leading zero
    case (r_slot)
      2'd3:    w_lz_blank = (r_shadow[15:12] == 4'd0);
      2'd2:    w_lz_blank = (r_shadow[15:8] == 8'd0);
      2'd1:    w_lz_blank = (r_shadow[15:4] == 12'd0);
      default: w_lz_blank = 1'b0;
    endcase
`endif
    w_blank = w_lz_blank || ((r_state == BLINK) && !r_bl_on);
  end

  // Registered anode/cathode drive; dp lit on every digit while highlighting
  always_ff @(posedge clk_mode or posedge rst) begin
    if (rst) begin
      r_seg_an  <= 4'b1111;
      r_seg_cat <= 8'hFF;
    end else if (w_blank) begin
      r_seg_an  <= 4'b1111;
      r_seg_cat <= 8'hFF;
    end else begin
      r_seg_an  <= ~(4'b0001 << r_slot);
      r_seg_cat <= {(r_state != HIGHLIGHT), w_seg7};
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// Bench for score_display_scan with SCAN_DIV=4, HIGHLIGHT_FRAMES=2, BLINK_FRAMES=2.
// Vectors list digits, game_over and the per-frame display mode expected afterwards.
// Mode letters: N = digits shown dp off, H = digits shown dp lit, O = fully blanked.
module tb_score_display_scan;

  logic       clk_mode = 1'b0;
  logic       rst;
  logic [3:0] d3, d2, d1, d0;
  logic       game_over;
  logic [3:0] seg_an;
  logic [7:0] seg_cat;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_mode = ~clk_mode;

  score_display_scan #(
    .SCAN_DIV        (4),
    .HIGHLIGHT_FRAMES(2),
    .BLINK_FRAMES    (2)
  ) u_dut (
    .clk_mode    (clk_mode),
    .rst         (rst),
    .score_digit3(d3),
    .score_digit2(d2),
    .score_digit1(d1),
    .score_digit0(d0),
    .game_over   (game_over),
    .seg_an      (seg_an),
    .seg_cat     (seg_cat),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    logic [15:0] dig;
    logic        go;
    string       modes;
  } vec_t;

  typedef struct {
    logic [15:0] an;
    logic [31:0] cat;
    string       tag;
  } frame_t;

  vec_t   vq[$];
  frame_t exp_q[$];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic frame_t build(input logic [15:0] dig, input byte m, input string tag);
    frame_t f;
    f.tag = tag;
    for (int s = 0; s < 4; s++) begin
      logic blank;
      logic [3:0] d;
      d = dig[4*s +: 4];
      blank = (m == "O");
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 3 && dig[15:12] == 4'd0) blank = 1'b1;
      if (s == 2 && dig[15:8] == 8'd0) blank = 1'b1;
      if (s == 1 && dig[15:4] == 12'd0) blank = 1'b1;
`endif
      if (blank) begin
        f.an[4*s +: 4]  = 4'hF;
        f.cat[8*s +: 8] = 8'hFF;
      end else begin
        f.an[4*s +: 4]  = ~(4'b0001 << s);
        f.cat[8*s +: 8] = {(m != "H"), seg7(d)};
      end
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_dig(input logic [15:0] nd);
    {d3, d2, d1, d0} = nd;
  endtask

  task automatic add_vec(input logic [15:0] dig, input logic go, input string modes);
    vec_t v;
    v.dig = dig;
    v.go = go;
    v.modes = modes;
    vq.push_back(v);
  endtask

  // Advance to the negedge right after the next frame_tick pulse, bounded.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk_mode);
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk_mode);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_tick timeout: got no pulse, expected one within 40 cycles");
    end
  endtask

  // Capture one whole frame (4 slots) and compare against the scoreboard head.
  task automatic capture(input logic chg, input logic [15:0] nd);
    frame_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard empty: got no expected frame, expected one queued");
      return;
    end
    e = exp_q.pop_front();
    wait_tick();
    repeat (2) @(posedge clk_mode);
    @(negedge clk_mode);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) repeat (4) @(negedge clk_mode);
      check($sformatf("%s an slot%0d", e.tag, s), 32'(seg_an), 32'(e.an[4*s +: 4]));
      check($sformatf("%s cat slot%0d", e.tag, s), 32'(seg_cat), 32'(e.cat[8*s +: 8]));
      if (s == 0 && chg) set_dig(nd);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    v = vq[vi];
    set_dig(v.dig);
    game_over = v.go;
    for (int i = 0; i < v.modes.len(); i++)
      exp_q.push_back(build(v.dig, v.modes[i], $sformatf("v%0d f%0d", vi, i)));
    for (int i = 0; i < v.modes.len(); i++)
      capture(1'b0, 16'h0000);
  endtask

  task automatic hand_tick_period();
    int n;
    wait_tick();
    n = 0;
    do begin
      @(negedge clk_mode);
      n++;
    end while (frame_tick !== 1'b1 && n < 64);
    check("frame_tick period", 32'(n), 32'd16);
  endtask

  task automatic hand_midframe_change();
    // old value must finish its frame even though the digits change after slot 0
    exp_q.push_back(build(16'h0000, "N", "midframe old"));
    capture(1'b1, 16'h0010);
  endtask

  task automatic hand_reset_mid_slot2();
    frame_t e;
    e = build(16'h0030, "N", "pre-reset");
    wait_tick();
    repeat (10) @(negedge clk_mode);
    check("pre-reset slot2 an", 32'(seg_an), 32'(e.an[11:8]));
    check("pre-reset slot2 cat", 32'(seg_cat), 32'(e.cat[23:16]));
    rst = 1'b1;
    #1;
    check("mid-reset an", 32'(seg_an), 32'hF);
    check("mid-reset cat", 32'(seg_cat), 32'hFF);
    check("mid-reset tick", 32'(frame_tick), 32'd0);
    @(negedge clk_mode);
    rst = 1'b0;
    @(posedge clk_mode);
    @(negedge clk_mode);
    check("post-reset2 slot0 an", 32'(seg_an), 32'hE);
    check("post-reset2 slot0 cat", 32'(seg_cat), 32'hC0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    game_over = 1'b0;
    set_dig(16'h1234);

    add_vec(16'h1234, 1'b0, "HHN");        // first snapshot differs from reset zero
    add_vec(16'h1234, 1'b0, "N");
    add_vec(16'h0000, 1'b0, "HHN");        // reset-to-zero counts as a change
    add_vec(16'h0010, 1'b0, "HHN");        // follows the mid-frame change
    add_vec(16'h00C5, 1'b0, "HHN");        // dash on digit1
    add_vec(16'h00C5, 1'b1, "NNOONNOO");   // blink, no change
    add_vec(16'h00C5, 1'b0, "N");
    add_vec(16'h9876, 1'b1, "NN");         // change while blinking: no highlight
    add_vec(16'h9876, 1'b0, "NN");
    add_vec(16'h0030, 1'b0, "HHN");
    add_vec(16'h0030, 1'b0, "HHN");        // after mid-frame reset, shadow is zero again

    repeat (3) @(negedge clk_mode);
    check("reset an", 32'(seg_an), 32'hF);
    check("reset cat", 32'(seg_cat), 32'hFF);
    check("reset tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    @(posedge clk_mode);
    @(negedge clk_mode);
    check("post-reset slot0 an", 32'(seg_an), 32'hE);
    check("post-reset slot0 cat", 32'(seg_cat), 32'hC0);

    for (int vi = 0; vi < vq.size(); vi++) begin
      run_vec(vi);
      if (vi == 1) hand_tick_period();
      if (vi == 2) hand_midframe_change();
      if (vi == 9) hand_reset_mid_slot2();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
